// File: rtl/vending_machine_param.sv
// Parametrised vending-machine controller: NUM_ITEMS products with per-item price and stock counter.
// Latency: a coin registers into credit next cycle, and vend_valid follows one cycle later. Every output is registered.
// No backpressure: pulse inputs are sampled every cycle. The optional restock port is enabled by `define VM_RESTOCK_EN.
module vending_machine_param #(
  parameter int NUM_ITEMS  = 5,
  parameter int ITEM_W     = 3,
  parameter int AMT_W      = 2,
  parameter int CREDIT_W   = 6,
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 10,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES =
    {CREDIT_W'(12), CREDIT_W'(10), CREDIT_W'(7), CREDIT_W'(5), CREDIT_W'(3)}
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         confirm,
  input  logic                         cancel,
  input  logic [2:0]                   coin,
  input  logic [ITEM_W-1:0]            item_sel,
  input  logic [AMT_W-1:0]             amt_sel,
`ifdef VM_RESTOCK_EN
  input  logic                         restock,
  input  logic [ITEM_W-1:0]            restock_item,
`endif
  output logic                         vend_valid,
  output logic [ITEM_W-1:0]            item_name,
  output logic [AMT_W-1:0]             item_amt,
  output logic [CREDIT_W-1:0]          change,
  output logic [CREDIT_W-1:0]          credit,
  output logic                         sel_err,
  output logic                         coin_reject,
  output logic [NUM_ITEMS*STOCK_W-1:0] stock,
  output logic [2:0]                   state
);

  localparam logic [2:0] S_IDLE    = 3'b000;
  localparam logic [2:0] S_COLLECT = 3'b001;
  localparam logic [2:0] S_VEND    = 3'b010;
  localparam logic [2:0] S_REFUND  = 3'b011;

  localparam int CW = CREDIT_W + AMT_W;  // width of price*qty before the overflow check
  localparam int SW = STOCK_W + AMT_W;   // common width for stock-vs-quantity compares
  localparam logic [CREDIT_W:0] CREDIT_MAX = {1'b0, {CREDIT_W{1'b1}}};

  logic [2:0]                           state_q, state_d;
  logic [CREDIT_W-1:0]                  credit_q, credit_d;
  logic [ITEM_W-1:0]                    item_q, item_d;
  logic [AMT_W-1:0]                     amt_q, amt_d;
  logic [CREDIT_W-1:0]                  cost_q, cost_d;
  logic                                 vend_q, vend_d;
  logic [ITEM_W-1:0]                    name_q, name_d;
  logic [AMT_W-1:0]                     amt_out_q, amt_out_d;
  logic [CREDIT_W-1:0]                  change_q, change_d;
  logic                                 sel_err_q, sel_err_d;
  logic                                 coin_rej_q, coin_rej_d;
  logic [NUM_ITEMS-1:0][STOCK_W-1:0]    stock_q, stock_d;

  logic [CREDIT_W-1:0] sel_price;
  logic [STOCK_W-1:0]  sel_stock;
  logic [CW-1:0]       cost_full;
  logic                order_ok;
  logic [CREDIT_W:0]   coin_val, coin_sum;
  logic                coin_onehot, coin_ok, coin_any;

  // Price/stock lookup for the requested item and validity of the whole order
  always_comb begin
    sel_price = '0;
    sel_stock = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (item_sel == ITEM_W'(i)) begin
        sel_price = PRICES[i*CREDIT_W +: CREDIT_W];
        sel_stock = stock_q[i];
      end
    end
    cost_full = CW'(sel_price) * CW'(amt_sel);
    order_ok  = ({1'b0, item_sel} < (ITEM_W+1)'(NUM_ITEMS)) &&
                (amt_sel != '0) &&
                (SW'(sel_stock) >= SW'(amt_sel)) &&
                (cost_full[CW-1:CREDIT_W] == '0);
  end

  // Coin decode; a coin is acceptable only if one-hot and the credit cannot overflow
  always_comb begin
    coin_val    = '0;
    coin_onehot = 1'b1;
    case (coin)
      3'b001:  coin_val = (CREDIT_W+1)'(1);
      3'b010:  coin_val = (CREDIT_W+1)'(5);
      3'b100:  coin_val = (CREDIT_W+1)'(10);
      default: coin_onehot = 1'b0;
    endcase
    coin_any = |coin;
    coin_sum = {1'b0, credit_q} + coin_val;
    coin_ok  = coin_onehot && (coin_sum <= CREDIT_MAX);
  end

  // Next-state and next-output computation for the order FSM and stock counters
  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    item_d     = item_q;
    amt_d      = amt_q;
    cost_d     = cost_q;
    vend_d     = 1'b0;
    name_d     = name_q;
    amt_out_d  = amt_out_q;
    change_d   = change_q;
    sel_err_d  = 1'b0;
    coin_rej_d = 1'b0;
    stock_d    = stock_q;
    case (state_q)
      S_IDLE: begin
        coin_rej_d = coin_any;
        if (confirm) begin
          if (order_ok) begin
            item_d  = item_sel;
            amt_d   = amt_sel;
            cost_d  = cost_full[CREDIT_W-1:0];
            state_d = S_COLLECT;
          end else begin
            sel_err_d = 1'b1;
          end
        end
`ifdef VM_RESTOCK_EN
        if (restock) begin
          for (int i = 0; i < NUM_ITEMS; i++) begin
            if (restock_item == ITEM_W'(i)) stock_d[i] = '1;
          end
        end
`endif
      end
      S_COLLECT: begin
        if (cancel) begin
          // A coin landing with cancel still counts and is returned in the refund
          if (coin_ok) credit_d = coin_sum[CREDIT_W-1:0];
          coin_rej_d = coin_any && !coin_ok;
          vend_d     = 1'b1;
          name_d     = item_q;
          amt_out_d  = '0;
          change_d   = coin_ok ? coin_sum[CREDIT_W-1:0] : credit_q;
          state_d    = S_REFUND;
        end else if (credit_q >= cost_q) begin
          // Credit is frozen once the cost is met so change matches what is shown
          coin_rej_d = coin_any;
          vend_d     = 1'b1;
          name_d     = item_q;
          amt_out_d  = amt_q;
          change_d   = credit_q - cost_q;
          state_d    = S_VEND;
        end else if (coin_ok) begin
          credit_d = coin_sum[CREDIT_W-1:0];
        end else begin
          coin_rej_d = coin_any;
        end
      end
      S_VEND: begin
        coin_rej_d = coin_any;
        credit_d   = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
          if (item_q == ITEM_W'(i)) begin
            stock_d[i] = (SW'(stock_q[i]) >= SW'(amt_q)) ? stock_q[i] - STOCK_W'(amt_q) : '0;
          end
        end
        state_d = S_IDLE;
      end
      S_REFUND: begin
        coin_rej_d = coin_any;
        credit_d   = '0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset drops any order in flight without a refund
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      credit_q   <= '0;
      item_q     <= '0;
      amt_q      <= '0;
      cost_q     <= '0;
      vend_q     <= 1'b0;
      name_q     <= '0;
      amt_out_q  <= '0;
      change_q   <= '0;
      sel_err_q  <= 1'b0;
      coin_rej_q <= 1'b0;
      stock_q    <= {NUM_ITEMS{STOCK_W'(STOCK_INIT)}};
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      item_q     <= item_d;
      amt_q      <= amt_d;
      cost_q     <= cost_d;
      vend_q     <= vend_d;
      name_q     <= name_d;
      amt_out_q  <= amt_out_d;
      change_q   <= change_d;
      sel_err_q  <= sel_err_d;
      coin_rej_q <= coin_rej_d;
      stock_q    <= stock_d;
    end
  end

  assign vend_valid  = vend_q;
  assign item_name   = name_q;
  assign item_amt    = amt_out_q;
  assign change      = change_q;
  assign credit      = credit_q;
  assign sel_err     = sel_err_q;
  assign coin_reject = coin_rej_q;
  assign stock       = stock_q;
  assign state       = state_q;

endmodule

// File: tb/tb_vending_machine_param.sv
// Testbench for vending_machine_param: directed orders, checked every cycle against an integer model.
// Item 4 is priced 21 here so that a 3-unit order costs 63 and credit can sit at 60 while collecting.
// Inputs change 2 time units after a rising edge; outputs are sampled on the falling edge.
module tb_vending_machine_param;
  localparam int NI = 5, IW = 3, AW = 2, CRW = 6, SWD = 4;
  localparam logic [NI*CRW-1:0] TB_PRICES = {6'd21, 6'd10, 6'd7, 6'd5, 6'd3};

  logic clk = 1'b0, rst = 1'b0, confirm = 1'b0, cancel = 1'b0;
  logic [2:0]  coin = '0;
  logic [IW-1:0] item_sel = '0;
  logic [AW-1:0] amt_sel = '0;
`ifdef VM_RESTOCK_EN
  logic restock = 1'b0;
  logic [IW-1:0] restock_item = '0;
`endif
  logic vend_valid, sel_err, coin_reject;
  logic [IW-1:0] item_name;
  logic [AW-1:0] item_amt;
  logic [CRW-1:0] change, credit;
  logic [NI*SWD-1:0] stock;
  logic [2:0] state;

  vending_machine_param #(.PRICES(TB_PRICES)) dut (
    .clk(clk), .rst(rst), .confirm(confirm), .cancel(cancel), .coin(coin),
    .item_sel(item_sel), .amt_sel(amt_sel),
`ifdef VM_RESTOCK_EN
    .restock(restock), .restock_item(restock_item),
`endif
    .vend_valid(vend_valid), .item_name(item_name), .item_amt(item_amt), .change(change),
    .credit(credit), .sel_err(sel_err), .coin_reject(coin_reject), .stock(stock), .state(state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  bit run = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase codes follow the externally visible state values: 0 idle, 1 collecting, 2 vending, 3 refunding
  int price [NI] = '{3, 5, 7, 10, 21};
  int m_phase = 0, m_credit = 0, m_item = 0, m_amt = 0, m_cost = 0;
  int m_stock [NI] = '{10, 10, 10, 10, 10};
  int e_vend = 0, e_name = 0, e_amt = 0, e_change = 0, e_serr = 0, e_crej = 0;

  always @(posedge clk or posedge rst) begin
    int cv;
    bit ok;
    if (rst) begin
      m_phase = 0; m_credit = 0; m_item = 0; m_amt = 0; m_cost = 0;
      e_vend = 0; e_name = 0; e_amt = 0; e_change = 0; e_serr = 0; e_crej = 0;
      for (int i = 0; i < NI; i++) m_stock[i] = 10;
    end else begin
      cv = (coin == 3'b001) ? 1 : (coin == 3'b010) ? 5 : (coin == 3'b100) ? 10 : 0;
      e_vend = 0; e_serr = 0; e_crej = 0;
      case (m_phase)
        0: begin
          e_crej = (coin != 0);
          if (confirm) begin
            ok = 1'b0;
            if (int'(item_sel) < NI && amt_sel != 0)
              ok = (m_stock[item_sel] >= int'(amt_sel)) && (price[item_sel] * int'(amt_sel) <= 63);
            if (ok) begin
              m_item = int'(item_sel); m_amt = int'(amt_sel);
              m_cost = price[item_sel] * int'(amt_sel); m_phase = 1;
            end else e_serr = 1;
          end
`ifdef VM_RESTOCK_EN
          if (restock && int'(restock_item) < NI) m_stock[restock_item] = 15;
`endif
        end
        1: begin
          if (cancel) begin
            if (cv != 0 && m_credit + cv <= 63) m_credit += cv;
            else e_crej = (coin != 0);
            e_vend = 1; e_name = m_item; e_amt = 0; e_change = m_credit; m_phase = 3;
          end else if (m_credit >= m_cost) begin
            e_crej = (coin != 0);
            e_vend = 1; e_name = m_item; e_amt = m_amt; e_change = m_credit - m_cost; m_phase = 2;
          end else if (cv != 0 && m_credit + cv <= 63) m_credit += cv;
          else e_crej = (coin != 0);
        end
        2: begin
          e_crej = (coin != 0);
          m_stock[m_item] = (m_stock[m_item] >= m_amt) ? m_stock[m_item] - m_amt : 0;
          m_credit = 0; m_phase = 0;
        end
        default: begin
          e_crej = (coin != 0);
          m_credit = 0; m_phase = 0;
        end
      endcase
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    logic [NI*SWD-1:0] es;
    if (run) begin
      for (int i = 0; i < NI; i++) es[i*SWD +: SWD] = SWD'(m_stock[i]);
      chk("state", int'(state), m_phase);
      chk("credit", int'(credit), m_credit);
      chk("vend_valid", int'(vend_valid), e_vend);
      chk("sel_err", int'(sel_err), e_serr);
      chk("coin_reject", int'(coin_reject), e_crej);
      chk("stock", int'(stock), int'(es));
      if (e_vend != 0) begin
        chk("item_name", int'(item_name), e_name);
        chk("item_amt", int'(item_amt), e_amt);
        chk("change", int'(change), e_change);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drv(input bit cf, input bit cn, input logic [2:0] c, input int it, input int am);
    @(posedge clk); #2;
    confirm = cf; cancel = cn; coin = c;
    item_sel = it[IW-1:0]; amt_sel = am[AW-1:0];
  endtask

  task automatic idle();
    drv(1'b0, 1'b0, 3'b000, 0, 0);
  endtask

  task automatic wait_vend(input string nm, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!vend_valid && n < 20);
    if (!vend_valid) chk({nm, "_vend_timeout"}, 0, 1);
  endtask

  task automatic pay(input int amount);
    int a;
    a = amount;
    while (a >= 10) begin drv(1'b0, 1'b0, 3'b100, 0, 0); a -= 10; end
    while (a >= 5)  begin drv(1'b0, 1'b0, 3'b010, 0, 0); a -= 5;  end
    while (a >= 1)  begin drv(1'b0, 1'b0, 3'b001, 0, 0); a -= 1;  end
    idle();
  endtask

  task automatic buy(input int it, input int am, input int cost);
    int n;
    drv(1'b1, 1'b0, 3'b000, it, am);
    pay(cost);
    wait_vend("buy", n);
    chk("buy_change", int'(change), 0);
  endtask

  initial begin
    int n;
    #1 rst = 1'b1;
    run = 1'b1;
    @(posedge clk); @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    chk("rst_state", int'(state), 0);
    chk("rst_credit", int'(credit), 0);
    chk("rst_stock", int'(stock), 32'hAAAAA);

    // 1: item 3 x3, three 10-unit coins, exact payment
    drv(1'b1, 1'b0, 3'b000, 3, 3);
    repeat (3) drv(1'b0, 1'b0, 3'b100, 0, 0);
    idle();
    wait_vend("t1", n);
    chk("t1_coin_to_vend", n, 2);
    chk("t1_name", int'(item_name), 3);
    chk("t1_amt", int'(item_amt), 3);
    chk("t1_change", int'(change), 0);
    @(negedge clk);
    chk("t1_stock3", int'(stock[12 +: 4]), 7);

    // 2: item 0 x1 paid with a 10 -> change 7
    drv(1'b1, 1'b0, 3'b000, 0, 1);
    drv(1'b0, 1'b0, 3'b100, 0, 0);
    idle();
    wait_vend("t2", n);
    chk("t2_name", int'(item_name), 0);
    chk("t2_change", int'(change), 7);
    @(negedge clk);
    chk("t2_credit_after", int'(credit), 0);

    // 3: cancel with a coin in the same cycle refunds 5+1
    drv(1'b1, 1'b0, 3'b000, 2, 2);
    drv(1'b0, 1'b0, 3'b010, 0, 0);
    drv(1'b0, 1'b1, 3'b001, 0, 0);
    idle();
    wait_vend("t3", n);
    chk("t3_change", int'(change), 6);
    chk("t3_amt", int'(item_amt), 0);
    chk("t3_name", int'(item_name), 2);
    @(negedge clk);
    chk("t3_stock2", int'(stock[8 +: 4]), 10);

    // 4: invalid selections, coin in idle, non-one-hot coin while collecting
    drv(1'b1, 1'b0, 3'b000, 5, 1); idle(); @(negedge clk);
    chk("t4_selerr_item", int'(sel_err), 1);
    chk("t4_state_item", int'(state), 0);
    drv(1'b1, 1'b0, 3'b000, 1, 0); idle(); @(negedge clk);
    chk("t4_selerr_amt", int'(sel_err), 1);
    drv(1'b0, 1'b0, 3'b100, 0, 0); idle(); @(negedge clk);
    chk("t4_idle_coin_rej", int'(coin_reject), 1);
    drv(1'b1, 1'b0, 3'b000, 1, 1);
    drv(1'b0, 1'b0, 3'b011, 0, 0); idle(); @(negedge clk);
    chk("t4_bad_coin_rej", int'(coin_reject), 1);
    chk("t4_bad_coin_credit", int'(credit), 0);
    drv(1'b0, 1'b1, 3'b000, 0, 0); idle();
    wait_vend("t4", n);
    chk("t4_refund_zero", int'(change), 0);

    // 5: credit saturation guard at 60 of 63, then reset mid-order
    drv(1'b1, 1'b0, 3'b000, 4, 3);
    repeat (7) drv(1'b0, 1'b0, 3'b100, 0, 0);
    idle(); @(negedge clk);
    chk("t5_overflow_rej", int'(coin_reject), 1);
    chk("t5_credit_held", int'(credit), 60);
    @(posedge clk); #2 rst = 1'b1;
    @(negedge clk);
    chk("t5_rst_credit", int'(credit), 0);
    chk("t5_rst_stock", int'(stock), 32'hAAAAA);
    @(posedge clk); #2 rst = 1'b0;

    // 6: drain item 4, then an order for it is rejected
    buy(4, 3, 63); buy(4, 3, 63); buy(4, 3, 63); buy(4, 1, 21);
    @(negedge clk);
    chk("t6_stock4_empty", int'(stock[16 +: 4]), 0);
    drv(1'b1, 1'b0, 3'b000, 4, 1); idle(); @(negedge clk);
    chk("t6_empty_selerr", int'(sel_err), 1);
`ifdef VM_RESTOCK_EN
    @(posedge clk); #2 restock = 1'b1; restock_item = 3'd4;
    @(posedge clk); #2 restock = 1'b0;
    @(negedge clk);
    chk("t6_restock4", int'(stock[16 +: 4]), 15);
    drv(1'b1, 1'b0, 3'b000, 4, 1); idle(); @(negedge clk);
    chk("t6_after_restock_state", int'(state), 1);
    drv(1'b0, 1'b1, 3'b000, 0, 0); idle();
    wait_vend("t6", n);
`endif
    idle(); idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
